// File: rtl/cordic_req_sched.sv
// ============================================================================
// Module   : cordic_req_sched
// Purpose  : Round-robin scheduler that shares one CE-gated CORDIC pipeline
//            between two angle requesters and routes results back by tag.
//            Optional counters enabled by CORDIC_REQ_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_req_sched #(
    parameter int W        = 32,
    parameter int PIPE_LAT = 20
) (
    input  logic         C,
    input  logic         CLR,
    input  logic         CE,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_angle,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_angle,
    output logic         req1_ready,
    output logic [W-1:0] pipe_angle,
    output logic         pipe_ce,
    input  logic [W-1:0] pipe_sine,
    input  logic [W-1:0] pipe_cos,
    output logic [W-1:0] rsp_sine,
    output logic [W-1:0] rsp_cos,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [5:0]   inflight
`ifdef CORDIC_REQ_SCHED_STATS_EN
    ,
    output logic [15:0]  issued0_cnt,
    output logic [15:0]  issued1_cnt,
    output logic [15:0]  stall_cnt
`endif
);

    localparam logic [5:0] LAT6 = 6'(PIPE_LAT);

    logic [PIPE_LAT-1:0] tok_vld;
    logic [PIPE_LAT-1:0] tok_tag;
    logic                tail_vld;
    logic                tail_tag;
    logic                stall;
    logic                grant0;
    logic                grant1;
    logic                issue;
    logic                consume;
    logic                last_grant;

    assign tail_vld = tok_vld[PIPE_LAT-1];
    assign tail_tag = tok_tag[PIPE_LAT-1];

    // Freeze everything when the owner of the tail result cannot take it.
    assign stall   = tail_vld & ~(tail_tag ? rsp1_ready : rsp0_ready);
    assign pipe_ce = CE & ~stall;

    // last_grant = 1 means requester 1 went last, so requester 0 wins a tie.
    assign grant0 = pipe_ce & req0_valid & (~req1_valid | last_grant);
    assign grant1 = pipe_ce & req1_valid & (~req0_valid | ~last_grant);
    assign issue  = grant0 | grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign pipe_angle = grant0 ? req0_angle : (grant1 ? req1_angle : '0);

    assign rsp0_valid = tail_vld & ~tail_tag;
    assign rsp1_valid = tail_vld & tail_tag;
    assign rsp_sine   = pipe_sine;
    assign rsp_cos    = pipe_cos;

    assign consume = CE & ((rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready));

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            tok_vld    <= '0;
            tok_tag    <= '0;
            inflight   <= '0;
            last_grant <= 1'b1;
        end else if (pipe_ce) begin
            tok_vld[0] <= issue;
            tok_tag[0] <= grant1;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tok_vld[i] <= tok_vld[i-1];
                tok_tag[i] <= tok_tag[i-1];
            end
            if (issue) begin
                last_grant <= grant1;
            end
            if (issue && !consume && inflight != LAT6) begin
                inflight <= inflight + 6'd1;
            end else if (!issue && consume && inflight != 6'd0) begin
                inflight <= inflight - 6'd1;
            end
        end
    end

`ifdef CORDIC_REQ_SCHED_STATS_EN
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            issued0_cnt <= '0;
            issued1_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (grant0 && issued0_cnt != 16'hFFFF) begin
                issued0_cnt <= issued0_cnt + 16'd1;
            end
            if (grant1 && issued1_cnt != 16'hFFFF) begin
                issued1_cnt <= issued1_cnt + 16'd1;
            end
            if (CE && stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/cordic_req_sched.md
Name: cordic_req_sched

Overview:
- Scheduler sharing one CE-gated CORDIC rotation pipeline (including the post_proc gain-compensation stages) between two angle requesters.
- Issues at most one angle per enabled cycle, round-robin between requesters.
- Tracks each in-flight sample's owner with a tag shift register matched to the pipeline depth.
- Routes the sine/cos result back to the owner; stalls the whole pipeline via its CE when the owning consumer is not ready.

Parameters:
- W, 32, data width of angle, sine and cos (two's complement)
- PIPE_LAT, 20, enabled-cycle latency from pipe_angle capture to matching pipe_sine/pipe_cos (CORDIC stages + 3 post_proc stages); legal range 1..63

Ports:
- C  in  1  clock, rising edge
- CLR  in  1  asynchronous active-high reset
- CE  in  1  global clock enable; no state advances while low
- req0_valid  in  1  requester 0 has an angle
- req0_angle  in  W  requester 0 angle
- req0_ready  out  1  requester 0 angle accepted this cycle
- req1_valid  in  1  requester 1 has an angle
- req1_angle  in  W  requester 1 angle
- req1_ready  out  1  requester 1 angle accepted this cycle
- pipe_angle  out  W  angle into shared pipeline
- pipe_ce  out  1  clock enable for shared pipeline
- pipe_sine  in  W  pipeline sine output (post gain compensation)
- pipe_cos  in  W  pipeline cos output
- rsp_sine  out  W  result sine, shared by both responders
- rsp_cos  out  W  result cos
- rsp0_valid  out  1  result belongs to requester 0
- rsp0_ready  in  1  consumer 0 accepts
- rsp1_valid  out  1  result belongs to requester 1
- rsp1_ready  in  1  consumer 1 accepts
- inflight  out  6  tokens currently in pipeline

Behaviour:
- Token shift register: PIPE_LAT entries of {vld, tag}. Entry 0 is loaded at issue; entry PIPE_LAT-1 is the tail.
- stall = tail.vld & ~(tag ? rsp1_ready : rsp0_ready).
- pipe_ce = CE & ~stall (combinational). Token register, inflight and round-robin state update only on edges where pipe_ce = 1.
- Grant (combinational, when pipe_ce = 1):
  - only one req valid -> that requester is granted;
  - both valid -> the requester not granted last is granted;
  - neither valid -> no grant.
- reqK_ready = pipe_ce & grantK. A transfer occurs when valid & ready are both high on the clock edge.
- pipe_angle = granted angle; 0 when no grant (a bubble). On a bubble edge a token with vld = 0 enters entry 0.
- last_grant updates only on an actual issue.
- Responses (all combinational from the tail):
  - rsp0_valid = tail.vld & ~tail.tag; rsp1_valid = tail.vld & tail.tag;
  - rsp_sine = pipe_sine, rsp_cos = pipe_cos.
- A result is consumed when rspK_valid & rspK_ready & CE. It stays stable while stalled because the pipeline is frozen.
- Latency: an angle issued at edge n returns at the tail after exactly PIPE_LAT further pipe_ce edges. With no stalls and CE = 1, rsp is valid PIPE_LAT cycles after the issuing edge.
- inflight:
  - +1 on issue, -1 on consumption, unchanged when both occur on the same edge;
  - saturates at PIPE_LAT (cannot be exceeded, since only one entry per edge).
- CE low: pipe_ce = 0, both req_ready = 0, rsp valids still reflect the tail, no consumption counted.
- Reset (CLR high, asynchronous):
  - all token vld = 0, tags = 0, inflight = 0, last_grant = 1 (requester 0 wins the first tie);
  - rsp0_valid = rsp1_valid = 0 immediately; pipe_ce = CE; req ready per grant rule.
- Reset mid-flight: all in-flight tokens are discarded. Stale pipeline data is never presented, because no tail vld is set. The pipeline datapath itself is not reset.
- Stall while a request is waiting: req_ready = 0, request held by requester, no grant-state change.

Optional Feature:
- Macro: CORDIC_REQ_SCHED_STATS_EN.
- When defined, adds outputs:
  - issued0_cnt, 16 bits;
  - issued1_cnt, 16 bits;
  - stall_cnt, 16 bits.
- issuedK_cnt counts transfers per requester. stall_cnt counts cycles with CE & stall.
- All three are saturating at 16'hFFFF and cleared by CLR.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- PIPE_LAT = 20, CE = 1, rsp ready high. req0 sends 0x2000_0000 at cycle 0 -> req0_ready = 1 at cycle 0; rsp0_valid = 1 exactly at cycle 20 with rsp_sine/rsp_cos equal to the pipeline model output; rsp1_valid never set; inflight 1 -> 0.
- Both requesters valid continuously for 8 cycles -> grants alternate 0,1,0,1… starting with 0 after reset; responses return in the same order with matching tags; inflight reaches 8.
- Tail owned by requester 1 with rsp1_ready = 0 for 5 cycles -> pipe_ce = 0, req ready = 0 and rsp_sine stable for those 5 cycles; stall_cnt = 5 when stats are enabled; resumes without loss.
- CE held low 3 cycles mid-stream -> no token movement; latency stretches by exactly 3 cycles; stats do not count them as stalls.
- CLR pulsed with 10 tokens in flight -> rsp valids drop asynchronously; no responses are produced for the discarded tokens afterwards; inflight = 0; next tie is granted to requester 0.
- Stats: 70000 req0 issues -> issued0_cnt saturates at 0xFFFF.
